// File: rtl/cyp_tx_fifo_pkg.sv
// Shared definitions for the FX2 EP6 IN transmit path: FSM encoding and
// endpoint addresses driven onto the FX2 FIFOADR pins.
package cyp_tx_fifo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TX_PRE = 2'd1,
      ST_TX     = 2'd2,
      ST_PKTEND = 2'd3
   } tx_state_t;

   localparam logic [1:0] EP2_ADDR = 2'b00;
   localparam logic [1:0] EP6_ADDR = 2'b10;
   localparam int         FD_W     = 16;

endpackage

// File: rtl/asyn_fifo_top.sv
// Gray-pointer async FIFO. Pointers are ASIZE bits including the wrap bit,
// so storage is 2**(ASIZE-1) words. rdata is registered: valid the cycle after ren.
module asyn_fifo_top #(
   parameter int DATAWIDTH = 16,
   parameter int ASIZE     = 10
) (
   input  logic                 wclk,
   input  logic                 rclk,
   input  logic                 rst_n,
   input  logic                 wen,
   input  logic [DATAWIDTH-1:0] wdata,
   output logic                 wfull,
   input  logic                 ren,
   output logic [DATAWIDTH-1:0] rdata,
   output logic                 rempty
);
   localparam int AW    = ASIZE - 1;
   localparam int DEPTH = 1 << AW;
   // full when write pointer leads read pointer by a whole lap: top two gray bits differ
   localparam logic [ASIZE-1:0] FULL_MASK = {2'b11, {(ASIZE-2){1'b0}}};

   logic [DATAWIDTH-1:0] mem [DEPTH];
   logic [ASIZE-1:0]     wbin, wgray, wbin_nxt, wgray_nxt, rq1, rq2;
   logic [ASIZE-1:0]     rbin, rgray, rbin_nxt, rgray_nxt, wq1, wq2;
   logic                 winc, rinc;

   assign winc      = wen && !wfull;
   assign wbin_nxt  = wbin + {{(ASIZE-1){1'b0}}, winc};
   assign wgray_nxt = (wbin_nxt >> 1) ^ wbin_nxt;

   always_ff @(posedge wclk or negedge rst_n)
      if (!rst_n) begin
         wbin  <= '0;
         wgray <= '0;
         wfull <= 1'b0;
         rq1   <= '0;
         rq2   <= '0;
      end else begin
         wbin  <= wbin_nxt;
         wgray <= wgray_nxt;
         wfull <= (wgray_nxt == (rq2 ^ FULL_MASK));
         rq1   <= rgray;
         rq2   <= rq1;
      end

   always_ff @(posedge wclk)
      if (winc) mem[wbin[AW-1:0]] <= wdata;

   assign rinc      = ren && !rempty;
   assign rbin_nxt  = rbin + {{(ASIZE-1){1'b0}}, rinc};
   assign rgray_nxt = (rbin_nxt >> 1) ^ rbin_nxt;

   always_ff @(posedge rclk or negedge rst_n)
      if (!rst_n) begin
         rbin   <= '0;
         rgray  <= '0;
         rempty <= 1'b1;
         wq1    <= '0;
         wq2    <= '0;
      end else begin
         rbin   <= rbin_nxt;
         rgray  <= rgray_nxt;
         rempty <= (rgray_nxt == wq2);
         wq1    <= wgray;
         wq2    <= wq1;
      end

   always_ff @(posedge rclk)
      if (rinc) rdata <= mem[rbin[AW-1:0]];

endmodule

// File: rtl/cyp_tx_fifo.sv
// EP6 IN transmit path: SDRAM-side words cross into cyp_clk through an async
// FIFO, land in a 2-entry output buffer and are strobed into the FX2 with SLWR.
module cyp_tx_fifo
   import cyp_tx_fifo_pkg::*;
#(
   parameter int PKT_WORDS      = 256,
   parameter int PKTEND_TIMEOUT = 1024,
   parameter int ASIZE          = 10
) (
   input  logic            cyp_clk,
   input  logic            rst_n,
   input  logic            sdram_clk,
   input  logic            sdram_init_done,
   input  logic            fifo_wen,
   input  logic [FD_W-1:0] fifo_wdata,
   output logic            fifo_wfull,
   output logic            usb_clk,
   output logic [1:0]      usb_fifoaddr,
   output logic            usb_slcs,
   output logic            usb_sloe,
   output logic            usb_slrd,
   output logic            usb_slwr,
   output logic            usb_pktend,
   output logic [FD_W-1:0] usb_fd_o,
   output logic            usb_fd_oe,
   input  logic            usb_flagc,
   output logic            pa0
);
   localparam int WCW = $clog2(PKT_WORDS);
   localparam int ICW = $clog2(PKTEND_TIMEOUT + 1);

   tx_state_t             state;
   logic [FD_W-1:0]       rdata;
   logic                  rempty, ren, rd_vld, fire, all_empty, timeout;
   logic [1:0]            occ;
   logic [2:0]            pend;
   logic [1:0][FD_W-1:0]  obuf;
   logic [WCW-1:0]        word_cnt;
   logic [ICW-1:0]        idle_cnt;

   assign usb_clk  = cyp_clk;
   assign usb_slcs = 1'b0;
   assign usb_sloe = 1'b1;
   assign usb_slrd = 1'b1;
   assign pa0      = 1'b1;

   asyn_fifo_top #(.DATAWIDTH(FD_W), .ASIZE(ASIZE)) u_fifo (
      .wclk(sdram_clk), .rclk(cyp_clk), .rst_n(rst_n),
      .wen(fifo_wen), .wdata(fifo_wdata), .wfull(fifo_wfull),
      .ren(ren), .rdata(rdata), .rempty(rempty)
   );

   // flagc gates the strobe combinationally so a full EP6 never loses the head word
   assign fire      = (state == ST_TX) && (occ != 2'd0) && usb_flagc;
   assign usb_slwr  = !fire;
   assign usb_fd_o  = obuf[0];
   assign pend      = {1'b0, occ} + {2'b0, rd_vld} - {2'b0, fire};
   assign ren       = !rempty && (pend < 3'd2);
   assign all_empty = (occ == 2'd0) && !rd_vld && rempty;
   assign timeout   = (idle_cnt == ICW'(PKTEND_TIMEOUT));

   always_ff @(posedge cyp_clk or negedge rst_n)
      if (!rst_n) begin
         rd_vld <= 1'b0;
         occ    <= 2'd0;
         obuf   <= '0;
      end else begin
         rd_vld <= ren;
         case ({rd_vld, fire})
            2'b01: begin obuf[0] <= obuf[1]; occ <= occ - 2'd1; end
            2'b10: begin obuf[occ[0]] <= rdata; occ <= occ + 2'd1; end
            2'b11:
               if (occ == 2'd2) begin
                  obuf[0] <= obuf[1];
                  obuf[1] <= rdata;
               end else
                  obuf[0] <= rdata;
            default: ;
         endcase
      end

   // a wrapped word_cnt means the FX2 committed the packet itself: nothing to time out
   always_ff @(posedge cyp_clk or negedge rst_n)
      if (!rst_n) begin
         word_cnt <= '0;
         idle_cnt <= '0;
      end else begin
         if (state == ST_PKTEND)  word_cnt <= '0;
         else if (fire)           word_cnt <= word_cnt + WCW'(1);
         if (fire || word_cnt == '0 || state == ST_PKTEND) idle_cnt <= '0;
         else if (all_empty && !timeout)                    idle_cnt <= idle_cnt + ICW'(1);
      end

   always_ff @(posedge cyp_clk or negedge rst_n)
      if (!rst_n) begin
         state        <= ST_IDLE;
         usb_fd_oe    <= 1'b0;
         usb_pktend   <= 1'b1;
         usb_fifoaddr <= EP2_ADDR;
      end else begin
         case (state)
            ST_IDLE:
               if (timeout && usb_flagc) begin
                  state        <= ST_PKTEND;
                  usb_fd_oe    <= 1'b1;
                  usb_pktend   <= 1'b0;
                  usb_fifoaddr <= EP6_ADDR;
               end else if (sdram_init_done && usb_flagc && (occ != 2'd0 || !rempty)) begin
                  state        <= ST_TX_PRE;
                  usb_fd_oe    <= 1'b1;
                  usb_fifoaddr <= EP6_ADDR;
               end
            ST_TX_PRE: state <= ST_TX;
            ST_TX:
               if (!usb_flagc || all_empty) begin
                  state     <= ST_IDLE;
                  usb_fd_oe <= 1'b0;
               end
            ST_PKTEND: begin
               state      <= ST_IDLE;
               usb_fd_oe  <= 1'b0;
               usb_pktend <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end

endmodule
